// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU sequencer.
// Control codes, slice operation fields and sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bundle between the ALU control decoder
// and the bit-serial sequencer.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic             ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;
  logic             done_o;

  modport master (
    output start_i, src1_i, src2_i, ctrl_i,
    input  ready_o, result_o, zero_o,
    input  cout_o, overflow_o, done_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, ctrl_i,
    output ready_o, result_o, zero_o,
    output cout_o, overflow_o, done_o
  );

endinterface

// File: rtl/alu_serial_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion,
// full-adder carry chain and AND/OR/SUM/LESS result mux.
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout,
  output logic       set
);

  logic aa;
  logic bb;

  assign aa   = a ^ a_invert;
  assign bb   = b ^ b_invert;
  assign set  = aa ^ bb ^ cin;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  always_comb begin
    result = 1'b0;
    unique case (1'b1)
      (operation == OP_AND): result = aa & bb;
      (operation == OP_OR):  result = aa | bb;
      (operation == OP_ADD): result = set;
      (operation == OP_SLT): result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one 1-bit slice over WIDTH
// cycles, LSB first, then publishes result and flags.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic              clk_i,
  input logic              rst_n,
  alu_serial_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_FIN  = FIN;

  logic [1:0]       state;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [3:0]       ctrl_q;
  logic             carry;
  logic             cin_msb;
  logic             cout_msb;
  logic             set_msb;
  logic             s_res;
  logic             s_cout;
  logic             s_set;
  logic             last;
  logic [1:0]       op;
  logic [WIDTH-1:0] fin_res;

  assign op          = ctrl_q[1:0];
  assign last        = (idx == CNT_W'(WIDTH - 1));
  assign bus.ready_o = (state == S_IDLE);

  alu_serial_slice u_slice (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .less      (1'b0),
    .a_invert  (ctrl_q[3]),
    .b_invert  (ctrl_q[2]),
    .cin       (carry),
    .operation (op),
    .result    (s_res),
    .cout      (s_cout),
    .set       (s_set)
  );

  // SLT takes the raw MSB sum bit of A-B, not the overflow-corrected sign
  assign fin_res = (op == OP_SLT)
                 ? {{(WIDTH-1){1'b0}}, set_msb}
                 : r_sr;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      ctrl_q   <= '0;
      carry    <= 1'b0;
      cin_msb  <= 1'b0;
      cout_msb <= 1'b0;
      set_msb  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (bus.start_i) begin
            a_sr   <= bus.src1_i;
            b_sr   <= bus.src2_i;
            ctrl_q <= bus.ctrl_i;
            carry  <= bus.ctrl_i[2];
            idx    <= '0;
            state  <= S_RUN;
          end
        end
        (state == S_RUN): begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= {s_res, r_sr[WIDTH-1:1]};
          carry <= s_cout;
          if (last) begin
            cin_msb  <= carry;
            cout_msb <= s_cout;
            set_msb  <= s_set;
            state    <= S_FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        (state == S_FIN): begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b0;
      bus.cout_o     <= 1'b0;
      bus.overflow_o <= 1'b0;
      bus.done_o     <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      if (state == S_FIN) begin
        bus.result_o   <= fin_res;
        bus.zero_o     <= (fin_res == '0);
        bus.cout_o     <= (op == OP_ADD) & cout_msb;
        bus.overflow_o <= (op == OP_ADD) & (cin_msb ^ cout_msb);
        bus.done_o     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: arithmetic reference model,
// per-cycle output compare, directed and random operations.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference: plain integer arithmetic on the inverted operands
  function automatic logic [W+1:0] ref_op(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [3:0]   c
  );
    logic [W-1:0] a, b, r;
    logic [W:0]   s;
    longint       sv, lim;
    logic         co, ov;
    a   = c[3] ? ~x : x;
    b   = c[2] ? ~y : y;
    s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c[2]};
    sv  = longint'($signed(a)) + longint'($signed(b)) + longint'(c[2]);
    lim = longint'(1) << (W - 1);
    co  = 1'b0;
    ov  = 1'b0;
    case (c[1:0])
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: begin
        r  = s[W-1:0];
        co = s[W];
        ov = (sv >= lim) || (sv < -lim);
      end
      default: r = {{(W-1){1'b0}}, s[W-1]};
    endcase
    return {ov, co, r};
  endfunction

  // Model: countdown of cycles until the result appears
  int             m_left = 0;
  logic [W+1:0]   pend   = '0;
  logic [W-1:0]   e_res  = '0;
  logic           e_zero = 1'b0;
  logic           e_cout = 1'b0;
  logic           e_ovf  = 1'b0;
  logic           e_done = 1'b0;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      e_res  <= '0;
      e_zero <= 1'b0;
      e_cout <= 1'b0;
      e_ovf  <= 1'b0;
      e_done <= 1'b0;
    end else begin
      e_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          e_res  <= pend[W-1:0];
          e_cout <= pend[W];
          e_ovf  <= pend[W+1];
          e_zero <= (pend[W-1:0] == '0);
          e_done <= 1'b1;
        end
      end else if (bus.start_i) begin
        pend   <= ref_op(bus.src1_i, bus.src2_i, bus.ctrl_i);
        m_left <= W + 1;
      end
    end
  end

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W+4:0] dut_out();
    return {bus.ready_o, bus.done_o, bus.zero_o,
            bus.cout_o, bus.overflow_o, bus.result_o};
  endfunction

  task automatic issue(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [3:0]   c
  );
    int n;
    n = 0;
    while (m_left != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (m_left != 0) chk("issue timeout", 64'(m_left), 64'd0);
    bus.start_i = 1'b1;
    bus.src1_i  = a;
    bus.src2_i  = b;
    bus.ctrl_i  = c;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    bus.ctrl_i  = 4'($urandom);
  endtask

  task automatic wait_done(output int cyc, output bit rdy_low);
    cyc     = 0;
    rdy_low = 1'b1;
    do begin
      @(negedge clk_i);
      cyc++;
      if (!bus.done_o && bus.ready_o) rdy_low = 1'b0;
    end while (!bus.done_o && cyc < 60);
  endtask

  task automatic directed(
    input string        nm,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [3:0]   c,
    input logic [W-1:0] er,
    input logic         ez,
    input logic         ec,
    input logic         ev
  );
    int cyc;
    bit rl;
    issue(a, b, c);
    wait_done(cyc, rl);
    chk({nm, " latency"}, 64'(cyc), 64'(W + 1));
    chk({nm, " busy"}, 64'(rl), 64'd1);
    chk({nm, " dut"},
        64'({bus.zero_o, bus.cout_o, bus.overflow_o, bus.result_o}),
        64'({ez, ec, ev, er}));
    chk({nm, " model"},
        64'({e_zero, e_cout, e_ovf, e_res}),
        64'({ez, ec, ev, er}));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    int nd;
    bit rl;

    bus.start_i = 1'b0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    bus.ctrl_i  = '0;

    #1;
    chk("reset state", 64'(dut_out()), 64'({1'b1, 36'd0}));

    fork
      forever begin
        @(negedge clk_i);
        chk("cycle",
            64'(dut_out()),
            64'({m_left == 0, e_done, e_zero, e_cout, e_ovf, e_res}));
      end
    join_none

    repeat (2) @(negedge clk_i);
    #2 rst_n = 1'b1;
    @(negedge clk_i);

    directed("add", 7, 5, ALU_ADD, 12, 0, 0, 0);
    directed("sub", 5, 5, ALU_SUB, 0, 1, 1, 0);
    directed("slt lt", 3, 7, ALU_SLT, 1, 0, 0, 0);
    chk("b2b in done cycle", 64'(bus.done_o), 64'd1);
    directed("slt b2b", 7, 3, ALU_SLT, 0, 1, 0, 0);
    directed("add ovf", 32'h7FFF_FFFF, 32'h1, ALU_ADD,
             32'h8000_0000, 0, 0, 1);
    directed("nor", 32'hF0F0_F0F0, 32'h0F0F_0F00, ALU_NOR,
             32'h0000_000F, 0, 0, 0);
    directed("and", 32'hF0F0_F0F0, 32'h0F0F_0F00, ALU_AND,
             32'h0, 1, 0, 0);

    // A start pulse while busy must not disturb the running op
    issue(100, 23, ALU_ADD);
    repeat (5) @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.src1_i  = 32'hDEAD_BEEF;
    bus.src2_i  = 32'h1;
    bus.ctrl_i  = ALU_SUB;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    wait_done(cyc, rl);
    chk("busy start latency", 64'(cyc), 64'(W + 1 - 6));
    chk("busy start result", 64'(bus.result_o), 64'd123);
    nd = 0;
    repeat (W + 4) begin
      @(negedge clk_i);
      if (bus.done_o) nd++;
    end
    chk("busy start no extra done", 64'(nd), 64'd0);

    // Abort mid-run: outputs clear at once, no done follows
    issue(32'h1234_5678, 32'h1, ALU_ADD);
    repeat (10) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1 chk("reset abort", 64'(dut_out()), 64'({1'b1, 36'd0}));
    repeat (2) @(negedge clk_i);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (W + 5) begin
      @(negedge clk_i);
      if (bus.done_o) nd++;
    end
    chk("no done after abort", 64'(nd), 64'd0);
    directed("add after reset", 1, 1, ALU_ADD, 2, 0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      issue(pick(), pick(), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.src1_i  = pick();
        bus.src2_i  = pick();
        bus.ctrl_i  = 4'($urandom);
        @(negedge clk_i);
        bus.start_i = 1'b0;
      end
    end

    cyc = 0;
    while (m_left != 0 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    repeat (3) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial 32-bit ALU sequencer: the control-side initiator that decodes a 4-bit ALU control code into per-bit slice controls and drives a single 1-bit ALU slice over WIDTH cycles.
- Accepts one operation per handshake.
- Produces a registered WIDTH-bit result plus zero/carry/overflow flags.
- Sits between the ALU control decoder and the register-file write-back, as a low-area replacement for the ripple-carry array.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥2)
- CNT_W, $clog2(WIDTH), bit-index counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request; accepted only when ready_o=1
- ready_o  out  1  high only in IDLE
- src1_i  in  WIDTH  operand A, sampled at accept
- src2_i  in  WIDTH  operand B, sampled at accept
- ctrl_i  in  4  ALU control, sampled at accept: [3]=A_invert, [2]=B_invert, [1:0]=operation (00 AND, 01 OR, 10 ADD, 11 SLT)
- result_o  out  WIDTH  registered result, held until next done_o
- zero_o  out  1  result_o==0
- cout_o  out  1  carry out of MSB (operation 10 only, else 0)
- overflow_o  out  1  signed overflow (operation 10 only, else 0)
- done_o  out  1  one-cycle pulse, outputs valid

## Operation
Decoding is generic from the three ctrl fields; there is no illegal code. Canonical codes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT
- 1100 NOR

Per-bit slice behaviour:
- a = A[i]^A_invert, b = B[i]^B_invert.
- op 00 → a&b; op 01 → a|b; op 10 → a^b^c; op 11 → less input.
- The carry chain (c_next = ab|ac|bc) and set = a^b^c are computed for every op, so SLT uses the true subtraction sum bit.
- The initial carry is B_invert.

FSM states:
- IDLE: ready_o=1. On start_i, latch operands, ctrl and carry=B_invert; clear idx; go to RUN.
- RUN: each cycle processes bit idx, LSB first. The slice result shifts into the result shift register and the carry register updates. At idx=WIDTH-1, capture the MSB carry-in/carry-out and MSB set, then go to FIN. Otherwise idx++.
- FIN: write result_o, zero_o, cout_o, overflow_o and pulse done_o; go to IDLE.
  - SLT: result_o = {WIDTH-1 zeros, set_msb}, where set_msb is the uncorrected sign of A-B.
  - Op 10: overflow_o = cin_msb^cout_msb.
  - Other ops: cout_o = 0, overflow_o = 0.

Boundary conditions:
- start_i outside IDLE is ignored; there is no queueing.
- Operand or ctrl changes after accept have no effect.
- Back-to-back operation: start_i may be accepted in the cycle done_o is high (FSM already in IDLE).
- Reset (any state, including mid-RUN): immediately go to IDLE with ready_o=1. All other outputs clear: result_o=0, zero_o=0, cout_o=0, overflow_o=0, done_o=0. No partial result is ever exposed.

## Timing
- Accept at edge T.
- Bits 0..WIDTH-1 are processed on edges T+1..T+WIDTH.
- Outputs update and done_o rises after edge T+WIDTH+1; latency is WIDTH+1 cycles (33 for WIDTH=32).
- ready_o falls after edge T and rises with done_o.
- Throughput: one operation per WIDTH+1 cycles.
- Flags update only on the done_o edge.

## Structure
- Shared package alu_pkg:
  - ALU_* ctrl code constants (AND, OR, ADD, SUB, SLT, NOR)
  - operation field constants OP_AND/OP_OR/OP_ADD/OP_SLT
  - state enum IDLE/RUN/FIN
- One sub-module, alu_serial_slice: combinational 1-bit slice.
  - Inputs: a, b, less, A_invert, B_invert, cin, operation.
  - Outputs: result, cout, set.
  - Its less input is tied 0; SLT substitution happens in FIN.
- The top module holds the FSM, idx counter, operand shift registers, carry register and output registers.

## Test plan
- ADD: ctrl 0010, 7+5 → result 12, zero 0, cout 0, overflow 0; done_o exactly 33 cycles after accept, ready_o low in between.
- SUB: ctrl 0110, 5-5 → result 0, zero 1, cout 1, overflow 0.
- SLT: ctrl 0111, 3 vs 7 → result 1. Then back-to-back in the done cycle, 7 vs 3 → result 0.
- ADD overflow: 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow 1, cout 0.
- NOR: ctrl 1100, 0xF0F0F0F0 / 0x0F0F0F00 → 0x0000000F. Same operands with AND → 0x00000000, zero 1.
- Busy and reset:
  - start_i pulsed mid-RUN with new operands → ignored, and the first result is unchanged.
  - rst_n low at bit 10 → ready_o=1 and all outputs 0 immediately.
  - No done_o follows the aborted operation.
  - A fresh ADD 1+1 → 2 after 33 cycles.
